// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle RV32I control sequencer.
// Each instruction steps through FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB).
// MEM stalls on iData_Ready when MEM_HANDSHAKE=1. Illegal opcodes park the FSM in TRAP.
// Every cycle that writes the PC retires one instruction and bumps oRetire_Cnt.
//
// Ports:
//   iClk, iRst                 clock (rising edge), synchronous active-high reset
//   iInst_Code                 instruction register contents (valid from DECODE on)
//   iBr_Taken                  branch comparator result
//   iData_Ready                data memory completed the access
//   oFunct3                    iInst_Code[14:12] passthrough
//   oALU_Control/oALUSrcMuxSel ALU operation / operand B select (0 rs2, 1 imm)
//   oIR_WrEn, oPC_WrEn         IR latch / PC update enables
//   oPCSrcSel                  0 PC+4, 1 PC+imm, 2 ALU result
//   oRegWrEn, oRFWDSrcSel      RF write / writeback source (0 ALU .. 4 PC+4)
//   oData_RdEn, oData_WrEn     data memory strobes
//   oIllegal                   sticky illegal-opcode flag (TRAP state)
//   oState                     FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WB=4 TRAP=5
//   oRetire_Cnt                retired instruction count, wraps silently
//
// Handshake: the data memory sees a strobe held high for the whole of MEM.
// iData_Ready=1 in a MEM cycle completes the access, and the FSM leaves MEM on that edge.
module mc_control_unit #(
  parameter int INST_W        = 32,
  parameter int ALU_CTRL_W    = 4,
  parameter int CNT_W         = 32,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [INST_W-1:0]     iInst_Code,
  input  logic                  iBr_Taken,
  input  logic                  iData_Ready,
  output logic [2:0]            oFunct3,
  output logic [ALU_CTRL_W-1:0] oALU_Control,
  output logic                  oALUSrcMuxSel,
  output logic                  oIR_WrEn,
  output logic                  oPC_WrEn,
  output logic [1:0]            oPCSrcSel,
  output logic                  oRegWrEn,
  output logic [2:0]            oRFWDSrcSel,
  output logic                  oData_RdEn,
  output logic                  oData_WrEn,
  output logic                  oIllegal,
  output logic [2:0]            oState,
  output logic [CNT_W-1:0]      oRetire_Cnt
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_inst;

  assign opcode = iInst_Code[6:0];
  assign funct3 = iInst_Code[14:12];
  assign f7b5   = iInst_Code[30];
  // Register indices and immediates belong to the datapath, not to control.
  assign unused_inst = ^{iInst_Code[INST_W-1:31], iInst_Code[29:15], iInst_Code[11:7]};

  logic is_load, is_store, is_br, legal, mem_done;
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BR);
  assign legal    = (opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
                                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR});
  assign mem_done = MEM_HANDSHAKE ? iData_Ready : 1'b1;

  // ALU decode, encoded as {funct7[5], funct3}. For I-type, funct7[5] only
  // matters for shift-right (arith vs logical); elsewhere it is immediate bits.
  logic [3:0] alu_ctrl;
  logic       alu_src;
  always_comb begin
    alu_ctrl = 4'b0000;
    alu_src  = 1'b0;
    case (opcode)
      OP_R:                      alu_ctrl = {f7b5, funct3};
      OP_I: begin
        alu_ctrl = {(funct3 == 3'b101) & f7b5, funct3};
        alu_src  = 1'b1;
      end
      OP_LOAD, OP_STORE, OP_JALR: alu_src = 1'b1;
      OP_BR:                     alu_ctrl = 4'b1000;
      default:                   alu_ctrl = 4'b0000;
    endcase
  end

  logic       ir_wr, pc_wr, reg_wr, rd_en, wr_en;
  logic [1:0] pc_sel;
  logic [2:0] rfwd_sel;

  always_comb begin
    state_d  = state_q;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    reg_wr   = 1'b0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    pc_sel   = 2'd0;
    rfwd_sel = 3'd0;
    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (is_br) begin
          pc_wr   = 1'b1;
          pc_sel  = iBr_Taken ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        rd_en = is_load;
        wr_en = is_store;
        if (mem_done) begin
          if (is_store) begin
            pc_wr   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_FETCH;
        case (opcode)
          OP_JAL:   begin pc_sel = 2'd1; rfwd_sel = 3'd4; end
          OP_JALR:  begin pc_sel = 2'd2; rfwd_sel = 3'd4; end
          OP_LOAD:  rfwd_sel = 3'd1;
          OP_LUI:   rfwd_sel = 3'd2;
          OP_AUIPC: rfwd_sel = 3'd3;
          default:  rfwd_sel = 3'd0;
        endcase
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // ALU controls stay valid through MEM/WB so an unregistered ALU result
  // (address, JALR target) remains stable while it is consumed.
  logic alu_active;
  assign alu_active = (state_q inside {S_EXECUTE, S_MEM, S_WB});

  assign oFunct3       = funct3;
  assign oALU_Control  = alu_active ? ALU_CTRL_W'(alu_ctrl) : '0;
  assign oALUSrcMuxSel = alu_active & alu_src;
  // Reset suppresses every side effect in the same cycle, so a reset during
  // MEM abandons the access with no PC or register write.
  assign oIR_WrEn      = ir_wr  & ~iRst;
  assign oPC_WrEn      = pc_wr  & ~iRst;
  assign oRegWrEn      = reg_wr & ~iRst;
  assign oData_RdEn    = rd_en  & ~iRst;
  assign oData_WrEn    = wr_en  & ~iRst;
  assign oPCSrcSel     = pc_sel;
  assign oRFWDSrcSel   = rfwd_sel;
  assign oIllegal      = (state_q == S_TRAP);
  assign oState        = state_q;
  assign oRetire_Cnt   = retire_q;

  assign retire_d = oPC_WrEn ? retire_q + CNT_W'(1) : retire_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= S_FETCH;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      retire_q <= retire_d;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit (CNT_W=4 so counter wrap is reachable).
module tb_mc_control_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      inst;
  logic             br_taken;
  logic             data_ready;
  logic [2:0]       funct3;
  logic [3:0]       alu_ctrl;
  logic             alu_src;
  logic             ir_wr, pc_wr, reg_wr, rd_en, wr_en, illegal;
  logic [1:0]       pc_sel;
  logic [2:0]       rfwd_sel, state;
  logic [CNT_W-1:0] retire_cnt;

  mc_control_unit #(
    .INST_W(32), .ALU_CTRL_W(4), .CNT_W(CNT_W), .MEM_HANDSHAKE(1'b1)
  ) dut (
    .iClk(clk), .iRst(rst), .iInst_Code(inst), .iBr_Taken(br_taken),
    .iData_Ready(data_ready), .oFunct3(funct3), .oALU_Control(alu_ctrl),
    .oALUSrcMuxSel(alu_src), .oIR_WrEn(ir_wr), .oPC_WrEn(pc_wr),
    .oPCSrcSel(pc_sel), .oRegWrEn(reg_wr), .oRFWDSrcSel(rfwd_sel),
    .oData_RdEn(rd_en), .oData_WrEn(wr_en), .oIllegal(illegal),
    .oState(state), .oRetire_Cnt(retire_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int model_cnt = 0;

  // One instruction: stimulus plus its expected transaction-level outcome.
  typedef struct {
    logic [31:0] inst;
    int          w;       // cycles iData_Ready is held low in MEM
    logic        taken;
    logic [3:0]  alu;
    logic        src;
    logic [1:0]  pcsel;
    logic        reg_wr;
    logic [2:0]  rfwd;
    int          rd_cyc;
    int          wr_cyc;
  } vec_t;

  logic [2:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_ready = 1'b0;
    @(negedge clk);
    chk("reset_enables", {ir_wr, pc_wr, reg_wr, rd_en, wr_en}, 5'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = 0;
    chk("reset_state", state, 3'd0);
    chk("reset_illegal", illegal, 1'b0);
    chk("reset_cnt", retire_cnt, 0);
  endtask

  // Reference model: outcome of one instruction from the ISA-level rules.
  function automatic vec_t ref_model(input logic [31:0] i, input int w, input logic taken);
    vec_t v;
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    v = '{i, w, taken, 4'h0, 1'b0, 2'd0, 1'b1, 3'd0, 0, 0};
    case (op)
      7'b0110011: v.alu = {i[30], f3};
      7'b0010011: begin v.alu = {(f3 == 3'b101) ? i[30] : 1'b0, f3}; v.src = 1'b1; end
      7'b0000011: begin v.src = 1'b1; v.rd_cyc = w + 1; v.rfwd = 3'd1; end
      7'b0100011: begin v.src = 1'b1; v.wr_cyc = w + 1; v.reg_wr = 1'b0; end
      7'b1100011: begin v.alu = 4'b1000; v.reg_wr = 1'b0; v.pcsel = taken ? 2'd1 : 2'd0; end
      7'b0110111: v.rfwd = 3'd2;
      7'b0010111: v.rfwd = 3'd3;
      7'b1101111: begin v.pcsel = 2'd1; v.rfwd = 3'd4; end
      7'b1100111: begin v.src = 1'b1; v.pcsel = 2'd2; v.rfwd = 3'd4; end
      default: ;
    endcase
    return v;
  endfunction

  // Driver + scoreboard for one instruction. Entered at posedge+1 with DUT in FETCH.
  task automatic run_and_check(input vec_t v);
    int len, mem_n, n_ir, n_pc, n_reg, n_rd, n_wr, stray, bad_state, pc_cyc;
    logic [3:0] s_alu;
    logic s_src, s_ir0;
    logic [1:0] s_pcsel;
    logic [2:0] s_rfwd;
    string tag;
    tag = $sformatf("%08h", v.inst);
    mem_n = v.rd_cyc + v.wr_cyc;
    exp_q.delete();
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    for (int k = 0; k < mem_n; k++) exp_q.push_back(3'd3);
    if (v.reg_wr) exp_q.push_back(3'd4);
    len = exp_q.size();
    n_ir = 0; n_pc = 0; n_reg = 0; n_rd = 0; n_wr = 0; stray = 0; bad_state = 0;
    pc_cyc = -1; s_alu = 'x; s_src = 'x; s_ir0 = 1'b0; s_pcsel = 'x; s_rfwd = 3'd0;
    inst = v.inst;
    br_taken = v.taken;
    for (int i = 0; i < len; i++) begin
      data_ready = (i >= 3 + v.w);
      @(negedge clk);
      if (state !== exp_q[i]) bad_state++;
      if (i == 0) s_ir0 = ir_wr;
      if (i == 2) begin s_alu = alu_ctrl; s_src = alu_src; end
      n_ir += int'(ir_wr); n_reg += int'(reg_wr); n_rd += int'(rd_en); n_wr += int'(wr_en);
      if (pc_wr) begin n_pc++; s_pcsel = pc_sel; pc_cyc = i; end
      if (reg_wr) s_rfwd = rfwd_sel;
      if ((!pc_wr && pc_sel != 2'd0) || (!reg_wr && rfwd_sel != 3'd0) ||
          $isunknown({alu_ctrl, alu_src, ir_wr, pc_wr, pc_sel, reg_wr, rfwd_sel, rd_en, wr_en}))
        stray++;
      @(posedge clk); #1;
    end
    data_ready = 1'b0;
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
    chk({"state_seq ", tag}, bad_state, 0);
    chk({"end_fetch ", tag}, state, 3'd0);
    chk({"ir_wr ", tag}, {s_ir0, 8'(n_ir)}, {1'b1, 8'd1});
    chk({"alu_ctrl ", tag}, s_alu, v.alu);
    chk({"alu_src ", tag}, s_src, v.src);
    chk({"pc_wr_once_last ", tag}, {8'(n_pc), 8'(pc_cyc)}, {8'd1, 8'(len - 1)});
    chk({"pc_sel ", tag}, s_pcsel, v.pcsel);
    chk({"reg_wr ", tag}, n_reg, int'(v.reg_wr));
    chk({"rfwd ", tag}, s_rfwd, v.rfwd);
    chk({"rd_cycles ", tag}, n_rd, v.rd_cyc);
    chk({"wr_cycles ", tag}, n_wr, v.wr_cyc);
    chk({"unused_sel ", tag}, stray, 0);
    chk({"retire_cnt ", tag}, retire_cnt, model_cnt);
  endtask

  vec_t tbl[16];
  logic [6:0] ops[9];

  initial begin
    tbl[0]  = '{32'h002081B3, 0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 3'd0, 0, 0}; // add
    tbl[1]  = '{32'h402081B3, 0, 1'b0, 4'h8, 1'b0, 2'd0, 1'b1, 3'd0, 0, 0}; // sub
    tbl[2]  = '{32'h4050D193, 0, 1'b0, 4'hD, 1'b1, 2'd0, 1'b1, 3'd0, 0, 0}; // srai
    tbl[3]  = '{32'h40008093, 0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 3'd0, 0, 0}; // addi, imm bit30 set
    tbl[4]  = '{32'h0020A023, 3, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 3'd0, 0, 4}; // sw, 3 wait
    tbl[5]  = '{32'h00208463, 0, 1'b1, 4'h8, 1'b0, 2'd1, 1'b0, 3'd0, 0, 0}; // beq taken
    tbl[6]  = '{32'h00208463, 0, 1'b0, 4'h8, 1'b0, 2'd0, 1'b0, 3'd0, 0, 0}; // beq not taken
    tbl[7]  = '{32'h0000A183, 2, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 3'd1, 3, 0}; // lw, 2 wait
    tbl[8]  = '{32'h123452B7, 0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 3'd2, 0, 0}; // lui
    tbl[9]  = '{32'h00001297, 0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 3'd3, 0, 0}; // auipc
    tbl[10] = '{32'h010000EF, 0, 1'b0, 4'h0, 1'b0, 2'd1, 1'b1, 3'd4, 0, 0}; // jal
    tbl[11] = '{32'h000100E7, 0, 1'b0, 4'h0, 1'b1, 2'd2, 1'b1, 3'd4, 0, 0}; // jalr
    tbl[12] = '{32'h0020A023, 0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 3'd0, 0, 1}; // sw, no wait
    tbl[13] = '{32'h0000A183, 0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 3'd1, 1, 0}; // lw, no wait
    tbl[14] = '{32'h0020E1B3, 0, 1'b0, 4'h6, 1'b0, 2'd0, 1'b1, 3'd0, 0, 0}; // or
    tbl[15] = '{32'h0050D193, 0, 1'b0, 4'h5, 1'b1, 2'd0, 1'b1, 3'd0, 0, 0}; // srli
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

    inst = 32'h0; br_taken = 1'b0; data_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Table-driven vectors
    for (int t = 0; t < 16; t++) run_and_check(tbl[t]);

    // Illegal opcode: TRAP after DECODE, sticky, no enables, cleared by reset
    do_reset();
    inst = 32'h0000007F;
    @(negedge clk); chk("trap_fetch", state, 3'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("trap_decode", state, 3'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("trap_state", state, 3'd5);
      chk("trap_illegal", illegal, 1'b1);
      chk("trap_enables", {ir_wr, pc_wr, reg_wr, rd_en, wr_en}, 5'b0);
      @(posedge clk); #1;
    end
    chk("trap_cnt", retire_cnt, 0);
    do_reset();

    // Reset in the middle of a stalled load
    run_and_check(tbl[0]);
    inst = 32'h0000A183; data_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("lw_mem_state", state, 3'd3);
    chk("lw_mem_rd", rd_en, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; data_ready = 1'b1;
    @(negedge clk);
    chk("lw_rst_enables", {pc_wr, reg_wr, rd_en}, 3'b0);
    @(posedge clk); #1;
    rst = 1'b0; data_ready = 1'b0;
    model_cnt = 0;
    chk("lw_rst_state", state, 3'd0);
    chk("lw_rst_cnt", retire_cnt, 0);
    @(negedge clk);
    chk("lw_rst_no_regwr", reg_wr, 1'b0);
    @(posedge clk); #1;
    do_reset();

    // Counter wrap: 15 retirements then the 16th returns to 0
    for (int k = 0; k < 15; k++) run_and_check(tbl[k % 4]);
    chk("wrap_15", retire_cnt, 4'd15);
    run_and_check(tbl[0]);
    chk("wrap_0", retire_cnt, 4'd0);

    // Randomized instructions against the reference model
    for (int r = 0; r < 150; r++) begin
      logic [31:0] ri;
      ri = $urandom;
      ri[6:0] = ops[$urandom_range(0, 8)];
      run_and_check(ref_model(ri, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1))));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB and waits on a data-memory ready handshake.
- Covers R, I, Load, S, B, LUI, AUIPC, JAL and JALR, traps illegal opcodes, and counts retired instructions.
- Sits between the instruction register / datapath and the data memory; drives every datapath enable and mux select.

Parameters:
- INST_W, 32, instruction width; decode fields are taken from bits [31:0].
- ALU_CTRL_W, 4, ALU control width; encoding is {funct7[5], funct3}, zero-extended if wider.
- CNT_W, 32, width of the retired-instruction counter.
- MEM_HANDSHAKE, 1. 1: MEM holds until iData_Ready. 0: MEM lasts exactly 1 cycle and iData_Ready is ignored.

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  synchronous, active-high reset.
- iInst_Code  in  INST_W  instruction register contents; valid from DECODE onward.
- iBr_Taken  in  1  branch comparator result, evaluated using oFunct3.
- iData_Ready  in  1  data memory has completed the access.
- oFunct3  out  3  iInst_Code[14:12], passthrough.
- oALU_Control  out  ALU_CTRL_W  ALU operation.
- oALUSrcMuxSel  out  1  0: rs2, 1: immediate.
- oIR_WrEn  out  1  latch the fetched instruction.
- oPC_WrEn  out  1  update PC.
- oPCSrcSel  out  2  0: PC+4, 1: PC+imm, 2: ALU result (JALR, bit0 cleared).
- oRegWrEn  out  1  register file write.
- oRFWDSrcSel  out  3  writeback source. 0: ALU, 1: load data, 2: imm (LUI), 3: PC+imm (AUIPC), 4: PC+4.
- oData_RdEn  out  1  data memory read strobe.
- oData_WrEn  out  1  data memory write strobe.
- oIllegal  out  1  sticky illegal-opcode flag.
- oState  out  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.
- oRetire_Cnt  out  CNT_W  retired instruction count.

Behaviour:
- **Reset.** iRst=1 at a clock edge sets state=FETCH, oIllegal=0, oRetire_Cnt=0.
  - While iRst=1, all enables/strobes are forced 0: IR, PC, Reg, Data_Rd, Data_Wr.
  - Reset mid-MEM abandons the access; no PC or register write occurs.
- **Output timing.** Outputs are combinational from the state register and iInst_Code (Moore-style plus decode). No output depends on iData_Ready except PC/Reg enables in MEM/WB as listed below.
- **FETCH.** oIR_WrEn=1; next state DECODE.
- **DECODE.** Opcode check. Legal: 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111. Legal -> EXECUTE; otherwise -> TRAP.
- **EXECUTE.** ALU controls are driven.
  - R: oALU_Control={f7[5],f3}, SrcSel=0.
  - I: {f7[5] only if f3==101 else 0, f3}, SrcSel=1.
  - Load/S/JALR: ADD, SrcSel=1.
  - B: SUB (4'b1000), SrcSel=0.
  - Other opcodes: ADD.
  - B: oPC_WrEn=1, oPCSrcSel = iBr_Taken ? 1 : 0, retire, next FETCH.
  - Load/S -> MEM; all others -> WB.
- **MEM.**
  - Load holds oData_RdEn=1; S holds oData_WrEn=1 for the whole state.
  - Exit condition: iData_Ready=1 (MEM_HANDSHAKE=1) or after 1 cycle (MEM_HANDSHAKE=0).
  - Load exits to WB.
  - S exits to FETCH, with oPC_WrEn=1 and PCSrcSel=0 on the exit cycle, and retires.
  - No timeout; the stall is unbounded.
- **WB.** oRegWrEn=1 and oPC_WrEn=1; next FETCH; retire.
  - PCSrcSel: JAL=1, JALR=2, else 0.
  - RFWDSrcSel: R/I=0, Load=1, LUI=2, AUIPC=3, JAL/JALR=4.
- **TRAP.** oIllegal=1; all enables 0; remains in TRAP until reset.
- **Retire counter.** Increments by 1 on every cycle with oPC_WrEn=1. Wraps from all-ones to 0 without a flag.
- **Cycle counts** (FETCH to next FETCH):
  - B = 3.
  - R/I/LUI/AUIPC/JAL/JALR = 4.
  - S = 4 + wait cycles.
  - Load = 5 + wait cycles.
- **Unused selects.** Undefined selects in any state drive 0, not X.

Test Plan:
- add x3,x1,x2 (0x002081B3) after reset -> states 0,1,2,4,0. ALU_Control=0000, RegWrEn=1 in WB only, RFWDSrcSel=0, Retire_Cnt=1.
- sub (0x402081B3) then srai (0x4050D193) -> ALU_Control 1000 then 1101. SrcSel 0 then 1.
- sw with iData_Ready held low 3 cycles in MEM -> oData_WrEn high 4 cycles. PC_WrEn pulses once on the ready cycle; RegWrEn never asserts.
- beq with iBr_Taken=1 then 0 -> 3-cycle instructions; PCSrcSel=1 then 0; ALU_Control=1000.
- Opcode 0x7F -> TRAP after DECODE; oIllegal=1 sticky; no enables. iRst=1 for one cycle -> FETCH, oIllegal=0.
- lw with iRst asserted while in MEM -> no RegWrEn/PC_WrEn; next state FETCH; Retire_Cnt=0. Preload the counter near wrap (CNT_W=4, 15 retirements) -> 16th wraps to 0.
